crc16_stream_ctrl: RTL and testbench

CRC16_STREAM_CTRL -- requirements
Module: crc16_stream_ctrl

---
 rtl/crc16_stream_if.sv | 31 +++
 rtl/crc16_stream_ctrl.sv | 98 +++++++++
 tb/tb_crc16_stream_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crc16_stream_if.sv
// Byte-stream handshake and CRC result bundle for crc16_stream_ctrl.
// byte_cnt_o exists only when CRC_STREAM_BYTE_CNT_EN is defined.
interface crc16_stream_if;
  logic        start_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [7:0]  data_i;
  logic        last_i;
  logic        busy_o;
  logic        crc_valid_o;
  logic [15:0] crc_o;
`ifdef CRC_STREAM_BYTE_CNT_EN
  logic [15:0] byte_cnt_o;
`endif

  modport master (
    output start_i, data_valid_i, data_i, last_i,
`ifdef CRC_STREAM_BYTE_CNT_EN
    input  byte_cnt_o,
`endif
    input  data_ready_o, busy_o, crc_valid_o, crc_o
  );

  modport slave (
    input  start_i, data_valid_i, data_i, last_i,
`ifdef CRC_STREAM_BYTE_CNT_EN
    output byte_cnt_o,
`endif
    output data_ready_o, busy_o, crc_valid_o, crc_o
  );
endinterface

// File: rtl/crc16_stream_ctrl.sv
// Streaming CRC-16 (poly 0x1021, MSB first), one nibble per cycle, one byte per two cycles.
// Optional byte counter output enabled by macro CRC_STREAM_BYTE_CNT_EN.
module crc16_stream_ctrl #(
  parameter logic [15:0] INIT_VAL = 16'hFFFF,
  parameter logic [15:0] XOR_OUT  = 16'h0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  crc16_stream_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StLo, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [3:0]  lo_nib_q, lo_nib_d;
  logic        last_q, last_d;

  // Nibble bit 3 is shifted in first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [3:0] nib);
    logic [15:0] c;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      if (c[15] ^ nib[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    lo_nib_d = lo_nib_q;
    last_d   = last_q;
    if (bus.start_i) begin
      state_d = StWait;
      crc_d   = INIT_VAL;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StWait: begin
          if (bus.data_valid_i) begin
            crc_d    = crc_step(crc_q, bus.data_i[7:4]);
            lo_nib_d = bus.data_i[3:0];
            last_d   = bus.last_i;
            state_d  = StLo;
          end
        end
        StLo: begin
          crc_d   = crc_step(crc_q, lo_nib_q);
          state_d = last_q ? StDone : StWait;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      crc_q    <= 16'h0000;
      lo_nib_q <= 4'h0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      lo_nib_q <= lo_nib_d;
      last_q   <= last_d;
    end
  end

  assign bus.data_ready_o = (state_q == StWait);
  assign bus.busy_o       = (state_q == StWait) || (state_q == StLo);
  assign bus.crc_valid_o  = (state_q == StDone);
  assign bus.crc_o        = crc_q ^ XOR_OUT;

`ifdef CRC_STREAM_BYTE_CNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        accept;

  assign accept = (state_q == StWait) && bus.data_valid_i && !bus.start_i;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (bus.start_i)  byte_cnt_d = 16'h0000;
    else if (accept)  byte_cnt_d = byte_cnt_q + 16'h0001;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) byte_cnt_q <= 16'h0000;
    else       byte_cnt_q <= byte_cnt_d;
  end

  assign bus.byte_cnt_o = byte_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_stream_ctrl.sv
// Self-checking bench: behavioural frame model plus directed CRC vectors and random traffic.
module tb_crc16_stream_ctrl;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   valid_cnt = 0;
  bit   chk_en = 1'b0;

  crc16_stream_if bus ();
  crc16_stream_if bus2 ();

  // Second instance sees identical stimulus but starts from zero.
  assign bus2.start_i      = bus.start_i;
  assign bus2.data_valid_i = bus.data_valid_i;
  assign bus2.data_i       = bus.data_i;
  assign bus2.last_i       = bus.last_i;

  crc16_stream_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  crc16_stream_ctrl #(
    .INIT_VAL (16'h0000)
  ) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Textbook byte-wise CRC-16/0x1021, MSB first.
  function automatic logic [15:0] crc16(input logic [15:0] init, input bq_t q);
    logic [15:0] c;
    c = init;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Behavioural model: frame open, low half pending, result pulse due.
  bit          m_open, m_lo, m_done, m_last, m_known;
  bq_t         m_q;
  logic [15:0] m_crc, m_crc2, m_cnt;

  task automatic model_step();
    if (rst) begin
      m_open = 0; m_lo = 0; m_done = 0; m_known = 1;
      m_crc = 16'h0000; m_crc2 = 16'h0000; m_cnt = 0;
      chk_en = 1'b1;
    end else if (bus.start_i) begin
      m_open = 1; m_lo = 0; m_done = 0; m_known = 0; m_cnt = 0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_open && m_lo) begin
      m_lo = 0;
      if (m_last) begin
        m_open = 0; m_done = 1; m_known = 1;
        m_crc  = crc16(16'hFFFF, m_q);
        m_crc2 = crc16(16'h0000, m_q);
      end
    end else if (m_open && bus.data_valid_i) begin
      m_q.push_back(bus.data_i);
      m_last = bus.last_i;
      m_lo   = 1;
      m_cnt  = m_cnt + 16'd1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (bus.crc_valid_o) valid_cnt <= valid_cnt + 1;
    if (chk_en) begin
      chk("ready", bus.data_ready_o, m_open && !m_lo);
      chk("busy", bus.busy_o, m_open);
      chk("crc_valid", bus.crc_valid_o, m_done);
      chk("crc_valid_i0", bus2.crc_valid_o, m_done);
      if (m_known) begin
        chk("crc", bus.crc_o, m_crc);
        chk("crc_i0", bus2.crc_o, m_crc2);
      end
`ifdef CRC_STREAM_BYTE_CNT_EN
      chk("byte_cnt", bus.byte_cnt_o, m_cnt);
`endif
    end
  end

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic l, output int hs);
    bit got;
    got = 0;
    hs  = 0;
    bus.data_valid_i = 1'b1;
    bus.data_i = b;
    bus.last_i = l;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.data_ready_o) begin
        hs  = cyc;
        got = 1;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("handshake_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int t);
    bit got;
    got = 0;
    t   = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.crc_valid_o) begin
        t   = cyc;
        got = 1;
      end
    end
    if (!got) chk("crc_valid_timeout", 0, 1);
  endtask

  initial begin
    bq_t  msg;
    bq_t  zero;
    int   hs, first, t, n0;

    bus.start_i = 0; bus.data_valid_i = 0; bus.data_i = 0; bus.last_i = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    msg  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    zero = '{8'h00};
    chk("model_check_ffff", crc16(16'hFFFF, msg), 16'h29B1);
    chk("model_check_0000", crc16(16'h0000, msg), 16'h31C3);
    chk("model_zero_byte", crc16(16'hFFFF, zero), 16'hE1F0);

    // "123456789" with valid held high
    pulse_start();
    first = 0;
    for (int i = 0; i < 9; i++) begin
      drive_byte(msg[i], i == 8, hs);
      if (i == 0) first = hs;
    end
    bus.data_valid_i = 0;
    wait_valid(t);
    chk("latency", t - first, 18);
    chk("crc_123456789", bus.crc_o, 16'h29B1);
    chk("crc_123456789_init0", bus2.crc_o, 16'h31C3);
`ifdef CRC_STREAM_BYTE_CNT_EN
    chk("byte_cnt_9", bus2.byte_cnt_o, 16'd9);
`endif
    @(posedge clk); #1;

    // Single zero byte
    pulse_start();
    drive_byte(8'h00, 1'b1, hs);
    bus.data_valid_i = 0;
    @(negedge clk);
    chk("ready_in_lo", bus.data_ready_o, 0);
    @(negedge clk);
    chk("single_valid", bus.crc_valid_o, 1);
    chk("ready_in_done", bus.data_ready_o, 0);
    chk("crc_zero_byte", bus.crc_o, 16'hE1F0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("crc_held_idle", bus.crc_o, 16'hE1F0);
    @(posedge clk); #1;

    // Restart during LO of byte 3
    pulse_start();
    for (int i = 0; i < 3; i++) drive_byte(msg[i], 1'b0, hs);
    n0 = valid_cnt;
    pulse_start();
    for (int i = 0; i < 9; i++) drive_byte(msg[i], i == 8, hs);
    bus.data_valid_i = 0;
    wait_valid(t);
    chk("crc_after_abort", bus.crc_o, 16'h29B1);
    @(posedge clk); #1;
    chk("abort_valid_pulses", valid_cnt - n0, 1);

    // Reset mid-frame, idle valid pulses, start+valid collision
    pulse_start();
    drive_byte(8'hAA, 1'b0, hs);
    drive_byte(8'hBB, 1'b0, hs);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", bus.data_ready_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_valid", bus.crc_valid_o, 0);
    chk("rst_crc", bus.crc_o, 16'h0000);
    n0 = valid_cnt;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.data_valid_i = 1;
      bus.data_i = 8'h5A;
      bus.last_i = 1;
      @(negedge clk);
      chk("idle_valid_ignored", bus.busy_o, 0);
    end
    @(posedge clk); #1;
    bus.start_i = 1; bus.data_valid_i = 1; bus.data_i = 8'h55; bus.last_i = 1;
    @(posedge clk); #1;
    bus.start_i = 0; bus.data_valid_i = 0;
    @(negedge clk);
    chk("collide_not_accepted", bus.data_ready_o, 1);
    chk("collide_busy", bus.busy_o, 1);
    chk("idle_no_pulse", valid_cnt - n0, 0);
`ifdef CRC_STREAM_BYTE_CNT_EN
    chk("collide_cnt", bus.byte_cnt_o, 16'd0);
`endif
    @(posedge clk); #1;

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.start_i      = ($urandom_range(0, 24) == 0);
      bus.data_valid_i = ($urandom_range(0, 3) != 0);
      bus.data_i       = 8'($urandom);
      bus.last_i       = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    rst = 0; bus.start_i = 0; bus.data_valid_i = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
